// File: rtl/simon_host.sv
// Host-side adapter for a SIMON block-cipher core: key and block handshakes toward
// the core, a two-entry result FIFO toward the host, and a per-phase watchdog.
module simon_host #(
    parameter int N  = 16,
    parameter int M  = 4,
    parameter int TO = 255
) (
    input  logic             clk,
    input  logic             nR,
    input  logic [M*N-1:0]   key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             mode_in,
    input  logic [2*N-1:0]   blk_in,
    input  logic             blk_valid,
    output logic             blk_ready,
    output logic [2*N-1:0]   blk_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_timeout,
    output logic             newData,
    output logic             newKey,
    output logic             enc_dec,
    output logic [2*N-1:0]   inData,
    output logic [M*N-1:0]   key,
    input  logic             loadData,
    input  logic             loadKey,
    input  logic             doneData,
    output logic             readData,
    input  logic [2*N-1:0]   outData
);
    localparam int WDW = $clog2(TO + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TO);

    typedef enum logic [2:0] {IDLE, KEY_REQ, DATA_REQ, WAIT_DONE, READ} state_t;

    state_t           state_q, state_d;
    logic             keyed_q, keyed_d;
    logic [WDW-1:0]   wd_q, wd_d, wd_inc;
    logic             err_q, err_d;
    logic             new_key_q, new_key_d;
    logic             new_data_q, new_data_d;
    logic             read_data_q, read_data_d;
    logic             enc_dec_q, enc_dec_d;
    logic [M*N-1:0]   key_q, key_d;
    logic [2*N-1:0]   in_data_q, in_data_d;
    logic [2*N-1:0]   head_q, head_d;
    logic [2*N-1:0]   tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             key_acc, blk_acc, push, pop;

    // Ready signals are forced low while reset is asserted so nothing is accepted then.
    assign key_ready = nR && (state_q == IDLE);
    assign blk_ready = nR && (state_q == IDLE) && keyed_q && !key_valid && (count_q < 2'd2);
    assign key_acc   = key_valid && key_ready;
    assign blk_acc   = blk_valid && blk_ready;
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign wd_inc    = wd_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        keyed_d     = keyed_q;
        wd_d        = wd_q;
        err_d       = err_q;
        new_key_d   = new_key_q;
        new_data_d  = new_data_q;
        read_data_d = read_data_q;
        enc_dec_d   = enc_dec_q;
        key_d       = key_q;
        in_data_d   = in_data_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        push        = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_acc) begin
                    key_d     = key_in;
                    enc_dec_d = mode_in;
                    new_key_d = 1'b1;
                    keyed_d   = 1'b0;
                    wd_d      = '0;
                    state_d   = KEY_REQ;
                end else if (blk_acc) begin
                    in_data_d  = blk_in;
                    new_data_d = 1'b1;
                    wd_d       = '0;
                    state_d    = DATA_REQ;
                end
            end
            KEY_REQ: begin
                if (loadKey) begin
                    new_key_d = 1'b0;
                    keyed_d   = 1'b1;
                    state_d   = IDLE;
                end
            end
            DATA_REQ: begin
                if (loadData) begin
                    new_data_d = 1'b0;
                    wd_d       = '0;
                    state_d    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (doneData) begin
                    push        = 1'b1;
                    read_data_d = 1'b1;
                    wd_d        = '0;
                    state_d     = READ;
                end
            end
            READ: begin
                if (!doneData) begin
                    read_data_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A phase that makes no progress for TO cycles is abandoned; queued results survive.
        if ((state_q != IDLE) && (state_d == state_q)) begin
            if (wd_inc == WD_LIMIT) begin
                err_d       = 1'b1;
                new_key_d   = 1'b0;
                new_data_d  = 1'b0;
                read_data_d = 1'b0;
                keyed_d     = 1'b0;
                wd_d        = '0;
                state_d     = IDLE;
            end else begin
                wd_d = wd_inc;
            end
        end

        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = outData;
                else                 tail_d = outData;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = outData;
                end else begin
                    head_d = tail_q;
                    tail_d = outData;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nR) begin
            state_q     <= IDLE;
            keyed_q     <= 1'b0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            new_key_q   <= 1'b0;
            new_data_q  <= 1'b0;
            read_data_q <= 1'b0;
            enc_dec_q   <= 1'b0;
            key_q       <= '0;
            in_data_q   <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            keyed_q     <= keyed_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            new_key_q   <= new_key_d;
            new_data_q  <= new_data_d;
            read_data_q <= read_data_d;
            enc_dec_q   <= enc_dec_d;
            key_q       <= key_d;
            in_data_q   <= in_data_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    assign err_timeout = err_q;
    assign newKey      = new_key_q;
    assign newData     = new_data_q;
    assign readData    = read_data_q;
    assign enc_dec     = enc_dec_q;
    assign key         = key_q;
    assign inData      = in_data_q;
    assign blk_out     = head_q;

endmodule

// File: tb/tb_simon_host.sv
// Bench for simon_host: a behavioural SIMON 32/64 core stub on the core side and a
// queue-based reference of expected results on the host side.
module tb_simon_host;
    localparam int N  = 16;
    localparam int M  = 4;
    localparam int TO = 255;

    logic             clk = 1'b0;
    logic             nR;
    logic [M*N-1:0]   key_in;
    logic             key_valid;
    logic             key_ready;
    logic             mode_in;
    logic [2*N-1:0]   blk_in;
    logic             blk_valid;
    logic             blk_ready;
    logic [2*N-1:0]   blk_out;
    logic             out_valid;
    logic             out_ready;
    logic             err_timeout;
    logic             newData;
    logic             newKey;
    logic             enc_dec;
    logic [2*N-1:0]   inData;
    logic [M*N-1:0]   key;
    logic             loadData = 1'b0;
    logic             loadKey = 1'b0;
    logic             doneData = 1'b0;
    logic             readData;
    logic [2*N-1:0]   outData = '0;

    int               errors = 0;
    int               checks = 0;
    logic [M*N-1:0]   model_key = '0;
    logic             model_mode = 1'b0;
    logic [2*N-1:0]   exp_q[$];
    logic             rand_ready = 1'b0;
    logic             stall_data = 1'b0;
    int               fixed_latency = 0;
    int               load_key_count = 0;

    always #5 clk = ~clk;

    simon_host #(.N(N), .M(M), .TO(TO)) dut (
        .clk(clk), .nR(nR), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
        .mode_in(mode_in), .blk_in(blk_in), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_out(blk_out), .out_valid(out_valid), .out_ready(out_ready),
        .err_timeout(err_timeout), .newData(newData), .newKey(newKey), .enc_dec(enc_dec),
        .inData(inData), .key(key), .loadData(loadData), .loadKey(loadKey),
        .doneData(doneData), .readData(readData), .outData(outData)
    );

    function automatic logic [15:0] simonF(input logic [15:0] x);
        return ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]};
    endfunction

    // SIMON 32/64 straight from the cipher definition: key schedule with z0, then 32 Feistel rounds.
    function automatic logic [31:0] simonModel(input logic [63:0] k, input logic enc, input logic [31:0] b);
        logic [15:0] rk [32];
        logic [15:0] x, y, t;
        logic [30:0] z;
        z = 31'b1111101000100101011000011100110;
        for (int i = 0; i < 4; i++) rk[i] = k[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = {rk[i-1][2:0], rk[i-1][15:3]} ^ rk[i-3];
            t = t ^ {t[0], t[15:1]};
            rk[i] = ~rk[i-4] ^ t ^ {15'd0, z[30-(i-4)]} ^ 16'd3;
        end
        x = b[31:16];
        y = b[15:0];
        if (enc) begin
            for (int i = 0; i < 32; i++) begin
                t = x; x = y ^ simonF(x) ^ rk[i]; y = t;
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                t = y; y = x ^ simonF(y) ^ rk[i]; x = t;
            end
        end
        return {x, y};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Core stub: random handshake delays, computes with the key it latched on loadKey.
    int             stub_stage = 0;
    int             stub_count = 0;
    logic [63:0]    stub_key = '0;
    logic           stub_mode = 1'b0;
    logic [31:0]    stub_result = '0;
    always @(negedge clk) begin
        if (loadKey) begin
            loadKey = 1'b0;
        end else if (newKey && $urandom_range(0, 2) == 0) begin
            loadKey = 1'b1;
            stub_key = key;
            stub_mode = enc_dec;
            load_key_count++;
        end
        if (loadData) begin
            loadData = 1'b0;
        end else if (stub_stage == 0 && newData && !stall_data && $urandom_range(0, 2) == 0) begin
            loadData = 1'b1;
            stub_result = simonModel(stub_key, stub_mode, inData);
            stub_count = (fixed_latency > 0) ? fixed_latency : $urandom_range(1, 4);
            stub_stage = 1;
        end else if (stub_stage == 1) begin
            if (stub_count == 0) begin
                doneData = 1'b1;
                outData = stub_result;
                stub_stage = 2;
            end else begin
                stub_count--;
            end
        end else if (stub_stage == 2) begin
            stub_count++;
            if (readData ? ($urandom_range(0, 1) == 1) : (stub_count > 8)) begin
                doneData = 1'b0;
                outData = '0;
                stub_stage = 0;
            end
        end
    end

    // Host-side consumer: every pop must match the oldest expected result.
    always begin
        @(negedge clk);
        #1;
        if (nR && out_valid && out_ready) begin
            checkOutput("popHasExpected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) checkOutput("blk_out", blk_out, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyKey(input logic [63:0] k, input logic m);
        int n = 0;
        tick();
        key_in = k; mode_in = m; key_valid = 1'b1;
        #1;
        while (!key_ready && n < 600) begin tick(); #1; n++; end
        checkOutput("keyAccept", key_ready, 1);
        model_key = k;
        model_mode = m;
        tick();
        key_valid = 1'b0;
        #1;
        checkOutput("newKeyRise", newKey, 1);
        checkOutput("keyToCore", key, k);
        checkOutput("encDecToCore", enc_dec, m);
        n = 0;
        while (newKey && n < 400) begin tick(); #1; n++; end
        checkOutput("newKeyDrop", newKey, 0);
    endtask

    task automatic applyStimulus(input logic [31:0] b, input logic expect_result);
        int n = 0;
        tick();
        blk_in = b; blk_valid = 1'b1;
        #1;
        while (!blk_ready && n < 600) begin tick(); #1; n++; end
        checkOutput("blkAccept", blk_ready, 1);
        if (expect_result) exp_q.push_back(simonModel(model_key, model_mode, b));
        tick();
        blk_valid = 1'b0;
        #1;
        checkOutput("newDataRise", newData, 1);
        checkOutput("inDataToCore", inData, b);
    endtask

    task automatic waitOutValid();
        int n = 0;
        while (!out_valid && n < 300) begin @(negedge clk); #1; n++; end
        checkOutput("outValidWait", out_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 600) begin @(negedge clk); #2; n++; end
        @(negedge clk);
        #2;
        checkOutput("drainQueue", exp_q.size(), 0);
        checkOutput("drainOutValid", out_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL globalTimeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] global time limit exceeded");
    end

    initial begin
        logic [63:0] rk;
        logic        rm, seen;
        logic [31:0] b0, b1, b2;
        int          n, lk;
        nR = 1'b0; key_in = '0; key_valid = 1'b0; mode_in = 1'b0;
        blk_in = '0; blk_valid = 1'b0; out_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rstKeyReady", key_ready, 0);
        checkOutput("rstBlkReady", blk_ready, 0);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstErr", err_timeout, 0);
        checkOutput("rstCoreStrobes", {newKey, newData, readData, enc_dec}, 0);
        checkOutput("rstKey", key, 0);
        checkOutput("rstInData", inData, 0);
        checkOutput("rstBlkOut", blk_out, 0);
        @(negedge clk);
        nR = 1'b1;
        #1;
        checkOutput("idleKeyReady", key_ready, 1);
        checkOutput("unkeyedBlkReady", blk_ready, 0);

        // Known-answer encrypt and decrypt.
        applyKey(64'h1918_1110_0908_0100, 1'b1);
        applyStimulus(32'h65656877, 1'b1);
        waitOutValid();
        checkOutput("katEncrypt", blk_out, 32'hc69be9bb);
        drain();
        out_ready = 1'b0;
        applyKey(64'h1918_1110_0908_0100, 1'b0);
        applyStimulus(32'hc69be9bb, 1'b1);
        waitOutValid();
        checkOutput("katDecrypt", blk_out, 32'h65656877);
        drain();

        // Key and block offered together: key goes first, block waits for the key handshake.
        rk = {$urandom, $urandom};
        rm = 1'($urandom_range(0, 1));
        @(negedge clk);
        key_in = rk; mode_in = rm; key_valid = 1'b1;
        blk_in = $urandom; blk_valid = 1'b1;
        #1;
        checkOutput("collideKeyReady", key_ready, 1);
        checkOutput("collideBlkReady", blk_ready, 0);
        model_key = rk;
        model_mode = rm;
        lk = load_key_count;
        @(negedge clk);
        key_valid = 1'b0;
        #1;
        checkOutput("collideNewKey", newKey, 1);
        checkOutput("collideNewData", newData, 0);
        n = 0;
        while (!blk_ready && n < 400) begin @(negedge clk); #1; n++; end
        checkOutput("collideBlkLater", blk_ready, 1);
        checkOutput("keyBeforeData", load_key_count > lk, 1);
        exp_q.push_back(simonModel(model_key, model_mode, blk_in));
        @(negedge clk);
        blk_valid = 1'b0;
        #1;
        checkOutput("collideNewDataRise", newData, 1);
        drain();

        // Randomized traffic with random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0) applyKey({$urandom, $urandom}, 1'($urandom_range(0, 1)));
            else applyStimulus($urandom, 1'b1);
        end
        drain();

        // Full FIFO holds off the third block until the host drains.
        out_ready = 1'b0;
        b0 = $urandom; b1 = $urandom; b2 = $urandom;
        applyStimulus(b0, 1'b1);
        applyStimulus(b1, 1'b1);
        repeat (80) @(negedge clk);
        @(negedge clk);
        blk_in = b2; blk_valid = 1'b1;
        #1;
        checkOutput("fullOutValid", out_valid, 1);
        checkOutput("fullHead", blk_out, exp_q[0]);
        for (int i = 0; i < 3; i++) begin
            checkOutput("fullBlkReady", blk_ready, 0);
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!blk_ready && n < 100) begin @(negedge clk); #1; n++; end
        checkOutput("thirdAccepted", blk_ready, 1);
        exp_q.push_back(simonModel(model_key, model_mode, b2));
        @(negedge clk);
        blk_valid = 1'b0;
        drain();

        // Core never takes the block: watchdog fires TO cycles after newData rises.
        stall_data = 1'b1;
        applyStimulus($urandom, 1'b0);
        n = 0;
        while (!err_timeout && n < TO + 20) begin @(negedge clk); #1; n++; end
        checkOutput("timeoutCycles", n, TO);
        checkOutput("timeoutErr", err_timeout, 1);
        checkOutput("timeoutNewData", newData, 0);
        @(negedge clk);
        blk_in = $urandom; blk_valid = 1'b1;
        #1;
        checkOutput("timeoutBlkReady", blk_ready, 0);
        checkOutput("timeoutKeyReady", key_ready, 1);
        @(negedge clk);
        blk_valid = 1'b0;
        stall_data = 1'b0;
        applyKey({$urandom, $urandom}, 1'($urandom_range(0, 1)));
        applyStimulus($urandom, 1'b1);
        drain();
        checkOutput("errSticky", err_timeout, 1);

        // Reset while waiting for the core result.
        fixed_latency = 12;
        applyStimulus($urandom, 1'b0);
        n = 0;
        while (newData && n < 200) begin @(negedge clk); #1; n++; end
        checkOutput("reachedWaitDone", newData, 0);
        @(negedge clk);
        nR = 1'b0;
        #1;
        checkOutput("midRstKeyReady", key_ready, 0);
        checkOutput("midRstBlkReady", blk_ready, 0);
        @(negedge clk);
        nR = 1'b1;
        #1;
        checkOutput("postRstStrobes", {newKey, newData, readData, enc_dec, out_valid, err_timeout}, 0);
        checkOutput("postRstKey", key, 0);
        checkOutput("postRstInData", inData, 0);
        checkOutput("postRstBlkOut", blk_out, 0);
        checkOutput("postRstKeyReady", key_ready, 1);
        exp_q.delete();
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (readData || out_valid || newData) seen = 1'b1;
        end
        checkOutput("postRstQuiet", seen, 0);
        fixed_latency = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simon_host.md
SIMON_HOST -- requirements
Module: simon_host

Interface
REQ-001 N, 16, word width in bits.
REQ-002 M, 4, key words.
REQ-003 TO, 255, watchdog limit in clk cycles per handshake phase.
REQ-004 clk  in  1  rising-edge clock; only clock.
REQ-005 nR  in  1  synchronous active-low reset.
REQ-006 key_in  in  M*N  key words; key_in[N-1:0] is word 0.
REQ-007 key_valid  in  1  host key-load request.
REQ-008 key_ready  out  1  key accepted when key_valid&key_ready.
REQ-009 mode_in  in  1  1=encrypt, 0=decrypt; sampled with key_in.
REQ-010 blk_in  in  2N  input block.
REQ-011 blk_valid  in  1  input block valid.
REQ-012 blk_ready  out  1  block accepted when blk_valid&blk_ready.
REQ-013 blk_out  out  2N  result block, FIFO head.
REQ-014 out_valid  out  1  result available.
REQ-015 out_ready  in  1  host consumes result.
REQ-016 err_timeout  out  1  sticky watchdog error.
REQ-017 newData  out  1  to core: block request.
REQ-018 newKey  out  1  to core: key request.
REQ-019 enc_dec  out  1  to core: direction.
REQ-020 inData  out  2N  to core: block.
REQ-021 key  out  M*N  to core: key.
REQ-022 loadData  in  1  from core: block taken.
REQ-023 loadKey  in  1  from core: key taken.
REQ-024 doneData  in  1  from core: outData valid.
REQ-025 readData  out  1  to core: result read.
REQ-026 outData  in  2N  from core: result.

Function
REQ-027 FSM states IDLE, KEY_REQ, DATA_REQ, WAIT_DONE, READ; 2-entry output FIFO; internal flag keyed.
REQ-028 key_ready=1 only in IDLE; on accept: key<=key_in, enc_dec<=mode_in, newKey<=1, keyed<=0, next KEY_REQ; key_valid and blk_valid in same IDLE cycle: key wins, block waits.
REQ-029 KEY_REQ: newKey, key held stable until loadKey sampled 1; next cycle newKey=0, keyed=1, IDLE.
REQ-030 blk_ready=1 only in IDLE with keyed=1, key_valid=0, FIFO count<2.
REQ-031 Block accept: inData<=blk_in, newData<=1, next DATA_REQ.
REQ-032 DATA_REQ: newData, inData held until loadData sampled 1; next cycle newData=0, WAIT_DONE.
REQ-033 WAIT_DONE: on doneData=1 push outData to FIFO, readData<=1, next READ.
REQ-034 READ: readData held until doneData sampled 0; next cycle readData=0, IDLE; one block in flight maximum.
REQ-035 FIFO: out_valid=(count>0); pop on out_valid&out_ready; simultaneous push and pop legal, count unchanged; order preserved; push never occurs when full (guaranteed by REQ-030).
REQ-036 loadKey, loadData, doneData ignored outside their wait states.
REQ-037 Watchdog: cleared on entry to KEY_REQ/DATA_REQ/WAIT_DONE/READ, +1 per cycle there; at TO: err_timeout<=1 (sticky), newKey=newData=readData=0, keyed=0, IDLE; FIFO contents kept.
REQ-038 enc_dec and key change only via REQ-028; direction switch needs a new key load.

Reset
REQ-039 nR=0 at posedge: state IDLE, FIFO empty, keyed=0, watchdog 0; newData, newKey, readData, enc_dec, inData, key, blk_out, out_valid, err_timeout all 0; key_ready=blk_ready=0 in reset cycle; mid-transaction reset abandons handshake with no further core signalling.

Verification
REQ-040 With SIMON 32/64 core: key 1918_1110_0908_0100, mode 1, blk 65656877 -> blk_out c69be9bb, out_valid=1.
REQ-041 Reload same key mode 0, blk c69be9bb -> blk_out 65656877.
REQ-042 out_ready=0, send 3 blocks -> 2 results queued, blk_ready=0; out_ready=1 -> results in order, third block then accepted.
REQ-043 Core stub never raises loadData -> err_timeout=1 TO cycles after newData rise, newData=0, blk_ready=0 until key reloaded.
REQ-044 nR=0 during WAIT_DONE -> next cycle all outputs 0, IDLE; later doneData pulse ignored, FIFO stays empty.
REQ-045 key_valid and blk_valid same IDLE cycle -> newKey first; newData only after loadKey handshake completes.
